weight_loader: RTL and testbench



---
 rtl/weight_pkg.sv | 18 +
 rtl/weight_deser.sv | 52 +++++
 rtl/weight_loader.sv | 145 ++++++++++++++
 tb/tb_weight_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared constants and state encoding for the serial weight loader.
// Address layout: hidden neuron j at HIDDEN_BASE+HIDDEN_FANIN*j, output neuron k at OUTPUT_BASE+OUTPUT_FANIN*k.
package weight_pkg;
   localparam int WIDTH        = 10;
   localparam int NUM_WORDS    = 65;
   localparam int ADDR_W       = 7;
   localparam int HIDDEN_BASE  = 0;
   localparam int OUTPUT_BASE  = 50;
   localparam int HIDDEN_FANIN = 10;
   localparam int OUTPUT_FANIN = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      CHECK  = 2'd2,
      FINISH = 2'd3
   } state_e;
endpackage

// File: rtl/weight_deser.sv
// MSB-first deserializer: shifts bits in on the LSB side and flags the WIDTH-th bit.
// word_o/word_valid_o are combinational so the parent can register them on the sampling edge.
module weight_deser #(
   parameter int WIDTH = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] word_o,
   output logic             word_valid_o
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next shift/count state and word completion
   always_comb begin
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      word_o       = {shift_q[WIDTH-2:0], bit_i};
      word_valid_o = 1'b0;
      if (clr_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (en_i) begin
         shift_d = word_o;
         if (cnt_q == LAST_BIT) begin
            cnt_d        = '0;
            word_valid_o = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         shift_d = shift_q;
      end
   end

   // shift register and bit counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/weight_loader.sv
// Serial weight loader: deserializes a frame of weights into RAM writes at consecutive
// addresses and validates the frame against a trailing modular-sum checksum word.
module weight_loader #(
   parameter int WIDTH     = weight_pkg::WIDTH,
   parameter int NUM_WORDS = weight_pkg::NUM_WORDS,
   parameter int ADDR_W    = weight_pkg::ADDR_W,
   parameter int BASE_ADDR = 0
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Start,
   input  logic              SerIn,
   input  logic              SerValid,
   output logic              WE,
   output logic [ADDR_W-1:0] WAddr,
   output logic [WIDTH-1:0]  WData,
   output logic              Busy,
   output logic              Done,
   output logic              Error
);
   import weight_pkg::*;

   localparam int WCNT_W = $clog2(NUM_WORDS + 1);
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d, waddr_q, waddr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d, sum_q, sum_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic               we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic               start_acc_s, deser_en_s, word_valid_s;
   logic [WIDTH-1:0]   word_s;

   // bits only count while a frame is loading or checking; the Start cycle is IDLE so its bit is dropped
   always_comb begin
      start_acc_s = Start && (state_q == IDLE);
      deser_en_s  = SerValid && ((state_q == LOAD) || (state_q == CHECK));
   end

   weight_deser #(.WIDTH(WIDTH)) u_deser (
      .clk_i        (Clock),
      .rst_ni       (Rst),
      .clr_i        (start_acc_s),
      .en_i         (deser_en_s),
      .bit_i        (SerIn),
      .word_o       (word_s),
      .word_valid_o (word_valid_s)
   );

   // frame FSM, counters and checksum next state
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      sum_d   = sum_q;
      wcnt_d  = wcnt_q;
      busy_d  = busy_q;
      err_d   = err_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_acc_s) begin
               state_d = LOAD;
               addr_d  = ADDR_W'(BASE_ADDR);
               wcnt_d  = '0;
               sum_d   = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (word_valid_s) begin
               we_d    = 1'b1;
               wdata_d = word_s;
               waddr_d = addr_q;
               addr_d  = addr_q + ADDR_W'(1);
               wcnt_d  = wcnt_q + WCNT_W'(1);
               sum_d   = sum_q + word_s;
               if (wcnt_q == LAST_WORD) begin
                  state_d = CHECK;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         CHECK: begin
            if (word_valid_s) begin
               err_d   = (word_s != sum_q);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FINISH;
            end else begin
               state_d = CHECK;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         sum_q   <= '0;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         sum_q   <= sum_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign WE    = we_q;
   assign WAddr = waddr_q;
   assign WData = wdata_q;
   assign Busy  = busy_q;
   assign Done  = done_q;
   assign Error = err_q;
endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: table of frame scenarios plus hand-written reset sequences.
module tb_weight_loader;
   localparam int W  = 10;
   localparam int N  = 65;
   localparam int AW = 7;

   logic          Clock = 1'b0;
   logic          Rst, Start, SerIn, SerValid;
   logic          WE, Busy, Done, Error;
   logic [AW-1:0] WAddr;
   logic [W-1:0]  WData;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int           pat;        // 0: word=index, 1: first two words -1 and -512
      logic [W-1:0] cs;         // checksum word sent
      int           gap;        // max idle cycles between bits
      bit           start_bit;  // SerValid asserted together with Start
      bit           mid_start;  // Start pulsed inside the frame
      bit           exp_err;
   } row_t;

   row_t          rows[4];
   logic [AW-1:0] wa_q[$];
   logic [W-1:0]  wd_q[$];
   logic          we_prev  = 1'b0;
   logic          prev_err = 1'b0;

   always #5 Clock = ~Clock;

   weight_loader #(.WIDTH(W), .NUM_WORDS(N), .ADDR_W(AW), .BASE_ADDR(0)) dut (
      .Clock(Clock), .Rst(Rst), .Start(Start), .SerIn(SerIn), .SerValid(SerValid),
      .WE(WE), .WAddr(WAddr), .WData(WData), .Busy(Busy), .Done(Done), .Error(Error)
   );

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [W-1:0] exp_word(input int pat, input int i);
      if (pat == 1 && i == 0)      return 10'h3FF;
      else if (pat == 1 && i == 1) return 10'h200;
      else                         return W'(i);
   endfunction

   // write monitor on the falling edge
   always @(negedge Clock) begin
      if (WE === 1'b1) begin
         chk("we_not_back_to_back", we_prev, 0);
         wa_q.push_back(WAddr);
         wd_q.push_back(WData);
      end
      we_prev = (WE === 1'b1);
   end

   task automatic send_word(input logic [W-1:0] w);
      for (int b = W - 1; b >= 0; b--) begin
         SerValid = 1'b1;
         SerIn    = w[b];
         tick();
      end
      SerValid = 1'b0;
   endtask

   task automatic run_frame(input row_t r);
      int           cycles;
      int           g;
      logic [W-1:0] w;
      wa_q.delete();
      wd_q.delete();
      chk("error_held_before_start", Error, prev_err);
      Start = 1'b1;
      if (r.start_bit) begin
         SerValid = 1'b1;
         SerIn    = 1'b1;
      end
      tick();
      cycles   = 1;
      Start    = 1'b0;
      SerValid = 1'b0;
      SerIn    = 1'b0;
      chk("busy_after_start", Busy, 1);
      chk("error_cleared_on_start", Error, 0);
      for (int i = 0; i <= N; i++) begin
         w = (i == N) ? r.cs : exp_word(r.pat, i);
         for (int b = W - 1; b >= 0; b--) begin
            g = (r.gap > 0) ? int'($urandom_range(r.gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
               tick();
               cycles++;
            end
            SerValid = 1'b1;
            SerIn    = w[b];
            if (r.mid_start && i == 30 && b == 5) Start = 1'b1;
            tick();
            cycles++;
            SerValid = 1'b0;
            Start    = 1'b0;
            SerIn    = 1'b0;
         end
         if (i < N) begin
            chk("no_early_done", Done, 0);
            chk("busy_during_frame", Busy, 1);
         end
      end
      chk("done_pulse", Done, 1);
      chk("busy_low_at_done", Busy, 0);
      chk("error_at_done", Error, r.exp_err);
      if (r.gap == 0) chk("frame_cycles", cycles, 1 + (N + 1) * W);
      tick();
      chk("done_one_cycle", Done, 0);
      chk("error_hold", Error, r.exp_err);
      chk("write_count", wa_q.size(), N);
      for (int i = 0; i < N && i < wa_q.size(); i++) begin
         chk("waddr", wa_q[i], i);
         chk("wdata", wd_q[i], exp_word(r.pat, i));
      end
      if (r.pat == 1 && wd_q.size() > 1) begin
         chk("signed_word0", $signed(wd_q[0]), -1);
         chk("signed_word1", $signed(wd_q[1]), -512);
      end
      repeat (3) tick();
      chk("error_still_held", Error, r.exp_err);
      prev_err = r.exp_err;
   endtask

   initial begin
      // checksums: index words sum 2080 -> 32; with -1/-512 first: 1023+512+2079=3614 -> 542
      rows[0] = '{pat: 0, cs: 10'd32,  gap: 0, start_bit: 1'b1, mid_start: 1'b0, exp_err: 1'b0};
      rows[1] = '{pat: 1, cs: 10'd542, gap: 0, start_bit: 1'b0, mid_start: 1'b0, exp_err: 1'b0};
      rows[2] = '{pat: 0, cs: 10'd33,  gap: 0, start_bit: 1'b0, mid_start: 1'b0, exp_err: 1'b1};
      rows[3] = '{pat: 0, cs: 10'd32,  gap: 3, start_bit: 1'b0, mid_start: 1'b1, exp_err: 1'b0};

      Rst = 1'b0; Start = 1'b0; SerIn = 1'b0; SerValid = 1'b0;
      repeat (3) tick();
      chk("rst_we", WE, 0);
      chk("rst_waddr", WAddr, 0);
      chk("rst_wdata", WData, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_error", Error, 0);
      Rst = 1'b1;
      tick();

      for (int k = 0; k < 8; k++) begin
         SerValid = 1'b1;
         SerIn    = k[0];
         tick();
      end
      SerValid = 1'b0;
      tick();
      chk("idle_ignores_bits", wa_q.size(), 0);
      chk("idle_not_busy", Busy, 0);

      // reset after 3 words + 4 bits
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 3; i++) send_word(W'(5 + i));
      for (int b = 0; b < 4; b++) begin
         SerValid = 1'b1;
         SerIn    = 1'b1;
         tick();
      end
      SerValid = 1'b0;
      Rst = 1'b0;
      #1;
      chk("midrst_we", WE, 0);
      chk("midrst_waddr", WAddr, 0);
      chk("midrst_wdata", WData, 0);
      chk("midrst_busy", Busy, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_error", Error, 0);
      chk("writes_before_reset", wa_q.size(), 3);
      if (wd_q.size() == 3) chk("third_word_before_reset", wd_q[2], 7);
      repeat (2) tick();
      Rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         SerValid = 1'b1;
         SerIn    = 1'b1;
         tick();
      end
      SerValid = 1'b0;
      tick();
      chk("no_stray_we_after_reset", wa_q.size(), 3);
      prev_err = 1'b0;

      for (int r = 0; r < 4; r++) run_frame(rows[r]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
